rs_disorder: RTL and testbench
==============================

// Module: rs_disorder
// PURPOSE
//  Out-of-order reservation station: entry storage and state that consumes the allocate/issue
//  selections of alloc_issue_disorder. Sits between dispatch (up to 2 instrs/cycle) and one
//  functional unit. Holds waiting instrs, wakes operands from 2 CDB ports, issues 1 ready instr/cycle.
// PARAMETERS
//  ENT_NUM  2   number of entries
//  ENT_SEL  1   entry index width, clog2(ENT_NUM)
//  TAG_W    6   rename tag width
//  DATA_W   32  operand data width
//  OP_W     8   opaque op/control payload width
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst_n            in   1       asynchronous active-low reset
//  i_flush          in   1       kill all entries
//  i_dp_vld_{1,2}   in   1       dispatch slot valid; slot 2 only with slot 1
//  i_dp_op_{1,2}    in   OP_W    op payload
//  i_dp_dst_{1,2}   in   TAG_W   destination tag
//  i_dp_s{1,2}_rdy_{1,2}  in 1   source operand already valid
//  i_dp_s{1,2}_tag_{1,2}  in TAG_W  source tag when not ready
//  i_dp_s{1,2}_dat_{1,2}  in DATA_W source value when ready
//  o_allocable      out  1       room for sum of dispatch valids (comb)
//  i_cdb_vld_{1,2}  in   1       result broadcast valid
//  i_cdb_tag_{1,2}  in   TAG_W   broadcast tag
//  i_cdb_dat_{1,2}  in   DATA_W  broadcast value
//  o_iss_vld        out  1       an entry is ready to issue
//  i_iss_rdy        in   1       FU accepts issue
//  o_iss_op         out  OP_W    issued op
//  o_iss_dst        out  TAG_W   issued dest tag
//  o_iss_s1, o_iss_s2  out DATA_W  issued operands
// BEHAVIOUR
//  - Reset: every busy/rdy bit 0 -> o_allocable=1, o_iss_vld=0, o_iss_* = 0.
//  - Per entry: busy, op, dst, s1/s2 {rdy,tag,dat}; ready = busy & s1.rdy & s2.rdy.
//  - i_req_num = i_dp_vld_1 + i_dp_vld_2 into selector; selector busy_vec = registered busy.
//  - Dispatch: if o_allocable, slot 1 writes alloc_sel_1, slot 2 writes alloc_sel_2; busy set
//    next edge. Dispatch with o_allocable=0 is a protocol error: ignored, assertion fires.
//  - Dispatch wakeup bypass: non-ready source whose tag matches a same-cycle CDB hit is written
//    ready with CDB data.
//  - Wakeup: busy entry, non-ready source, tag == valid cdb_tag -> rdy=1, dat=cdb_dat next edge.
//    Both CDB ports hit the same tag: port 1 wins (upstream guarantees unique tags).
//  - Issue: o_iss_vld = selector issue_sel_vld over ready vector; o_iss_* = mux of issue_sel
//    (comb from entry regs, 0-cycle). Handshake o_iss_vld & i_iss_rdy clears that busy next
//    edge. Wakeup arriving this cycle is visible to issue next cycle (no CDB->issue bypass).
//  - Freed entry is allocable from the cycle after issue (busy vector is registered).
//  - Outputs stable while o_iss_vld & !i_iss_rdy unless a higher-priority entry becomes ready.
//  - i_flush: all busy cleared next edge; overrides same-cycle dispatch, wakeup and issue.
//    o_iss_vld still reflects current state during the flush cycle; FU must drop it.
//  - Reset asserted mid-operation: all state cleared immediately (async), no issue pending.
// STRUCTURE
//  - Shared constants package (constants.vh): DP_NUM_WIDTH, TAG/DATA width defaults.
//  - One sub-module: alloc_issue_disorder (existing selector), instantiated once; entry array,
//    wakeup compare and issue mux live here. Optional per-entry generate loop, no further modules.
// TESTING
//  1 Reset, dispatch 2 fully-ready ops (ENT_NUM=2) -> o_allocable=0 next cycle; o_iss_vld=1,
//    i_iss_rdy=1 two cycles -> both issue, o_allocable=1 again.
//  2 Dispatch s1 tag=5 not ready; CDB tag=5 dat=0xDEAD next cycle -> o_iss_vld=1 the cycle
//    after, o_iss_s1=0xDEAD.
//  3 Dispatch with s2 tag=9 same cycle as CDB tag=9 -> entry written ready, issues next cycle.
//  4 Entry ready, i_iss_rdy=0 for 3 cycles -> o_iss_vld held 1 with stable payload, busy kept.
//  5 Full station + i_flush with dispatch asserted -> all entries empty, dispatch dropped,
//    o_iss_vld=0 next cycle.
//  6 Both CDB ports tag=3 with different data -> entry takes port 1 data.

Source files
------------

// File: rtl/rs_disorder_pkg.sv
// Shared widths and defaults for the reservation station and its allocate/issue selector.
package rs_disorder_pkg;
  localparam int RS_ENT_NUM   = 2;
  localparam int RS_ENT_SEL   = 1;
  localparam int RS_TAG_W     = 6;
  localparam int RS_DATA_W    = 32;
  localparam int RS_OP_W      = 8;
  localparam int DP_NUM_WIDTH = 2;

  function automatic logic [DP_NUM_WIDTH-1:0] dp_req_num(input logic vld_1, input logic vld_2);
    return {1'b0, vld_1} + {1'b0, vld_2};
  endfunction
endpackage

// File: rtl/rs_disorder_alloc_issue.sv
// Allocate/issue selector: lowest free entries for dispatch, lowest ready entry for issue.
module alloc_issue_disorder
  import rs_disorder_pkg::*;
#(
  parameter int ENT_NUM = RS_ENT_NUM,
  parameter int ENT_SEL = RS_ENT_SEL
) (
  input  logic [DP_NUM_WIDTH-1:0] i_req_num,
  input  logic [ENT_NUM-1:0]      i_busy_vec,
  input  logic [ENT_NUM-1:0]      i_ready_vec,
  output logic                    o_allocable,
  output logic [ENT_SEL-1:0]      o_alloc_sel_1,
  output logic [ENT_SEL-1:0]      o_alloc_sel_2,
  output logic                    o_issue_sel_vld,
  output logic [ENT_SEL-1:0]      o_issue_sel
);
  logic free_1;
  logic free_2;
  logic iss_hit;

  // Priority scan: the first free entry serves slot 1, the second free entry serves slot 2.
  always_comb begin
    free_1        = 1'b0;
    free_2        = 1'b0;
    iss_hit       = 1'b0;
    o_alloc_sel_1 = '0;
    o_alloc_sel_2 = '0;
    o_issue_sel   = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!i_busy_vec[i] && !free_1) begin
        free_1        = 1'b1;
        o_alloc_sel_1 = ENT_SEL'(i);
      end else if (!i_busy_vec[i] && !free_2) begin
        free_2        = 1'b1;
        o_alloc_sel_2 = ENT_SEL'(i);
      end else begin
        free_2 = free_2;
      end
      if (i_ready_vec[i] && !iss_hit) begin
        iss_hit     = 1'b1;
        o_issue_sel = ENT_SEL'(i);
      end else begin
        iss_hit = iss_hit;
      end
    end
    o_issue_sel_vld = iss_hit;
    case (i_req_num)
      2'd0:    o_allocable = 1'b1;
      2'd1:    o_allocable = free_1;
      2'd2:    o_allocable = free_2;
      default: o_allocable = 1'b0;
    endcase
  end
endmodule

// File: rtl/rs_disorder.sv
// Out-of-order reservation station: 2-wide dispatch, 2 CDB wakeup ports, 1 issue per cycle.
module rs_disorder
  import rs_disorder_pkg::*;
#(
  parameter int ENT_NUM = RS_ENT_NUM,
  parameter int ENT_SEL = RS_ENT_SEL,
  parameter int TAG_W   = RS_TAG_W,
  parameter int DATA_W  = RS_DATA_W,
  parameter int OP_W    = RS_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_dp_vld_1,
  input  logic [OP_W-1:0]   i_dp_op_1,
  input  logic [TAG_W-1:0]  i_dp_dst_1,
  input  logic              i_dp_s1_rdy_1,
  input  logic [TAG_W-1:0]  i_dp_s1_tag_1,
  input  logic [DATA_W-1:0] i_dp_s1_dat_1,
  input  logic              i_dp_s2_rdy_1,
  input  logic [TAG_W-1:0]  i_dp_s2_tag_1,
  input  logic [DATA_W-1:0] i_dp_s2_dat_1,
  input  logic              i_dp_vld_2,
  input  logic [OP_W-1:0]   i_dp_op_2,
  input  logic [TAG_W-1:0]  i_dp_dst_2,
  input  logic              i_dp_s1_rdy_2,
  input  logic [TAG_W-1:0]  i_dp_s1_tag_2,
  input  logic [DATA_W-1:0] i_dp_s1_dat_2,
  input  logic              i_dp_s2_rdy_2,
  input  logic [TAG_W-1:0]  i_dp_s2_tag_2,
  input  logic [DATA_W-1:0] i_dp_s2_dat_2,
  output logic              o_allocable,
  input  logic              i_cdb_vld_1,
  input  logic [TAG_W-1:0]  i_cdb_tag_1,
  input  logic [DATA_W-1:0] i_cdb_dat_1,
  input  logic              i_cdb_vld_2,
  input  logic [TAG_W-1:0]  i_cdb_tag_2,
  input  logic [DATA_W-1:0] i_cdb_dat_2,
  output logic              o_iss_vld,
  input  logic              i_iss_rdy,
  output logic [OP_W-1:0]   o_iss_op,
  output logic [TAG_W-1:0]  o_iss_dst,
  output logic [DATA_W-1:0] o_iss_s1,
  output logic [DATA_W-1:0] o_iss_s2
);
  logic [ENT_NUM-1:0]             busy_q, busy_d, s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [ENT_NUM-1:0][OP_W-1:0]   op_q, op_d;
  logic [ENT_NUM-1:0][TAG_W-1:0]  dst_q, dst_d, s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [ENT_NUM-1:0][DATA_W-1:0] s1_dat_q, s1_dat_d, s2_dat_q, s2_dat_d;
  logic [ENT_NUM-1:0]             ready_vec;
  logic [ENT_SEL-1:0]             issue_sel;

  logic [1:0]              dp_vld, dp_s1_rdy, dp_s2_rdy;
  logic [1:0][OP_W-1:0]    dp_op;
  logic [1:0][TAG_W-1:0]   dp_dst, dp_s1_tag, dp_s2_tag;
  logic [1:0][DATA_W-1:0]  dp_s1_dat, dp_s2_dat;
  logic [1:0][ENT_SEL-1:0] alloc_sel;

  assign dp_vld    = {i_dp_vld_2, i_dp_vld_1};
  assign dp_op     = {i_dp_op_2, i_dp_op_1};
  assign dp_dst    = {i_dp_dst_2, i_dp_dst_1};
  assign dp_s1_rdy = {i_dp_s1_rdy_2, i_dp_s1_rdy_1};
  assign dp_s1_tag = {i_dp_s1_tag_2, i_dp_s1_tag_1};
  assign dp_s1_dat = {i_dp_s1_dat_2, i_dp_s1_dat_1};
  assign dp_s2_rdy = {i_dp_s2_rdy_2, i_dp_s2_rdy_1};
  assign dp_s2_tag = {i_dp_s2_tag_2, i_dp_s2_tag_1};
  assign dp_s2_dat = {i_dp_s2_dat_2, i_dp_s2_dat_1};
  assign ready_vec = busy_q & s1_rdy_q & s2_rdy_q;

  alloc_issue_disorder #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL)) u_sel (
    .i_req_num      (dp_req_num(i_dp_vld_1, i_dp_vld_2)),
    .i_busy_vec     (busy_q),
    .i_ready_vec    (ready_vec),
    .o_allocable    (o_allocable),
    .o_alloc_sel_1  (alloc_sel[0]),
    .o_alloc_sel_2  (alloc_sel[1]),
    .o_issue_sel_vld(o_iss_vld),
    .o_issue_sel    (issue_sel)
  );

  // Returns {rdy, dat} after snooping both CDB ports; port 1 wins on a shared tag.
  function automatic logic [DATA_W:0] wake(input logic rdy, input logic [TAG_W-1:0] tag,
                                           input logic [DATA_W-1:0] dat);
    logic [DATA_W:0] res;
    if (!rdy && i_cdb_vld_1 && (i_cdb_tag_1 == tag)) res = {1'b1, i_cdb_dat_1};
    else if (!rdy && i_cdb_vld_2 && (i_cdb_tag_2 == tag)) res = {1'b1, i_cdb_dat_2};
    else res = {rdy, dat};
    return res;
  endfunction

  assign o_iss_op  = o_iss_vld ? op_q[issue_sel]     : '0;
  assign o_iss_dst = o_iss_vld ? dst_q[issue_sel]    : '0;
  assign o_iss_s1  = o_iss_vld ? s1_dat_q[issue_sel] : '0;
  assign o_iss_s2  = o_iss_vld ? s2_dat_q[issue_sel] : '0;

  // Next state: wakeup, issue retire, dispatch write (with CDB bypass), flush last.
  always_comb begin
    busy_d   = busy_q;   op_d     = op_q;     dst_d    = dst_q;
    s1_rdy_d = s1_rdy_q; s1_tag_d = s1_tag_q; s1_dat_d = s1_dat_q;
    s2_rdy_d = s2_rdy_q; s2_tag_d = s2_tag_q; s2_dat_d = s2_dat_q;
    for (int e = 0; e < ENT_NUM; e++) begin
      if (busy_q[e]) begin
        {s1_rdy_d[e], s1_dat_d[e]} = wake(s1_rdy_q[e], s1_tag_q[e], s1_dat_q[e]);
        {s2_rdy_d[e], s2_dat_d[e]} = wake(s2_rdy_q[e], s2_tag_q[e], s2_dat_q[e]);
      end else begin
        busy_d[e] = 1'b0;
      end
    end
    if (o_iss_vld && i_iss_rdy) busy_d[issue_sel] = 1'b0;
    else busy_d = busy_d;
    for (int s = 0; s < 2; s++) begin
      if (o_allocable && dp_vld[s]) begin
        busy_d[alloc_sel[s]]   = 1'b1;
        op_d[alloc_sel[s]]     = dp_op[s];
        dst_d[alloc_sel[s]]    = dp_dst[s];
        s1_tag_d[alloc_sel[s]] = dp_s1_tag[s];
        s2_tag_d[alloc_sel[s]] = dp_s2_tag[s];
        {s1_rdy_d[alloc_sel[s]], s1_dat_d[alloc_sel[s]]} = wake(dp_s1_rdy[s], dp_s1_tag[s], dp_s1_dat[s]);
        {s2_rdy_d[alloc_sel[s]], s2_dat_d[alloc_sel[s]]} = wake(dp_s2_rdy[s], dp_s2_tag[s], dp_s2_dat[s]);
      end else begin
        busy_d = busy_d;
      end
    end
    if (i_flush) begin
      busy_d   = '0;
      s1_rdy_d = '0;
      s2_rdy_d = '0;
    end else begin
      busy_d = busy_d;
    end
  end

  // Entry array registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0; op_q     <= '0; dst_q    <= '0;
      s1_rdy_q <= '0; s1_tag_q <= '0; s1_dat_q <= '0;
      s2_rdy_q <= '0; s2_tag_q <= '0; s2_dat_q <= '0;
    end else begin
      busy_q   <= busy_d;   op_q     <= op_d;     dst_q    <= dst_d;
      s1_rdy_q <= s1_rdy_d; s1_tag_q <= s1_tag_d; s1_dat_q <= s1_dat_d;
      s2_rdy_q <= s2_rdy_d; s2_tag_q <= s2_tag_d; s2_dat_q <= s2_dat_d;
    end
  end

  // A flush discards dispatch anyway, so a dispatch into a full station only matters without one.
  a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (!rst_n || i_flush)
    !((|dp_vld) && !o_allocable));
endmodule

// File: tb/tb_rs_disorder.sv
// Directed + randomized bench for rs_disorder against a queue-based instruction model.
module tb_rs_disorder;
  logic        clk = 1'b0, rst_n = 1'b0, i_flush, i_iss_rdy;
  logic        i_dp_vld_1, i_dp_s1_rdy_1, i_dp_s2_rdy_1, i_dp_vld_2, i_dp_s1_rdy_2, i_dp_s2_rdy_2;
  logic [7:0]  i_dp_op_1, i_dp_op_2, o_iss_op;
  logic [5:0]  i_dp_dst_1, i_dp_s1_tag_1, i_dp_s2_tag_1, i_dp_dst_2, i_dp_s1_tag_2, i_dp_s2_tag_2;
  logic [31:0] i_dp_s1_dat_1, i_dp_s2_dat_1, i_dp_s1_dat_2, i_dp_s2_dat_2;
  logic        i_cdb_vld_1, i_cdb_vld_2, o_allocable, o_iss_vld;
  logic [5:0]  i_cdb_tag_1, i_cdb_tag_2, o_iss_dst;
  logic [31:0] i_cdb_dat_1, i_cdb_dat_2, o_iss_s1, o_iss_s2;

  typedef struct {
    logic [7:0] op; logic [5:0] dst;
    logic r1; logic [5:0] t1; logic [31:0] d1;
    logic r2; logic [5:0] t2; logic [31:0] d2;
  } ins_t;
  ins_t mq[$];
  int n_tests = 0, n_fail = 0;
  logic [7:0] uid = 8'd1;
  logic [7:0] sv_op; logic [5:0] sv_dst; logic [31:0] sv_s1, sv_s2;

  rs_disorder dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_dp_vld_1(i_dp_vld_1), .i_dp_op_1(i_dp_op_1), .i_dp_dst_1(i_dp_dst_1),
    .i_dp_s1_rdy_1(i_dp_s1_rdy_1), .i_dp_s1_tag_1(i_dp_s1_tag_1), .i_dp_s1_dat_1(i_dp_s1_dat_1),
    .i_dp_s2_rdy_1(i_dp_s2_rdy_1), .i_dp_s2_tag_1(i_dp_s2_tag_1), .i_dp_s2_dat_1(i_dp_s2_dat_1),
    .i_dp_vld_2(i_dp_vld_2), .i_dp_op_2(i_dp_op_2), .i_dp_dst_2(i_dp_dst_2),
    .i_dp_s1_rdy_2(i_dp_s1_rdy_2), .i_dp_s1_tag_2(i_dp_s1_tag_2), .i_dp_s1_dat_2(i_dp_s1_dat_2),
    .i_dp_s2_rdy_2(i_dp_s2_rdy_2), .i_dp_s2_tag_2(i_dp_s2_tag_2), .i_dp_s2_dat_2(i_dp_s2_dat_2),
    .o_allocable(o_allocable),
    .i_cdb_vld_1(i_cdb_vld_1), .i_cdb_tag_1(i_cdb_tag_1), .i_cdb_dat_1(i_cdb_dat_1),
    .i_cdb_vld_2(i_cdb_vld_2), .i_cdb_tag_2(i_cdb_tag_2), .i_cdb_dat_2(i_cdb_dat_2),
    .o_iss_vld(o_iss_vld), .i_iss_rdy(i_iss_rdy), .o_iss_op(o_iss_op), .o_iss_dst(o_iss_dst),
    .o_iss_s1(o_iss_s1), .o_iss_s2(o_iss_s2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_flush = 1'b0; i_iss_rdy = 1'b0;
    i_dp_vld_1 = 1'b0; i_dp_op_1 = '0; i_dp_dst_1 = '0; i_dp_s1_rdy_1 = 1'b0; i_dp_s1_tag_1 = '0;
    i_dp_s1_dat_1 = '0; i_dp_s2_rdy_1 = 1'b0; i_dp_s2_tag_1 = '0; i_dp_s2_dat_1 = '0;
    i_dp_vld_2 = 1'b0; i_dp_op_2 = '0; i_dp_dst_2 = '0; i_dp_s1_rdy_2 = 1'b0; i_dp_s1_tag_2 = '0;
    i_dp_s1_dat_2 = '0; i_dp_s2_rdy_2 = 1'b0; i_dp_s2_tag_2 = '0; i_dp_s2_dat_2 = '0;
    i_cdb_vld_1 = 1'b0; i_cdb_tag_1 = '0; i_cdb_dat_1 = '0;
    i_cdb_vld_2 = 1'b0; i_cdb_tag_2 = '0; i_cdb_dat_2 = '0;
  endtask

  task automatic slot1(input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                       input logic r2, input logic [5:0] t2, input logic [31:0] d2);
    i_dp_vld_1 = 1'b1; i_dp_op_1 = uid; i_dp_dst_1 = uid[5:0]; uid = uid + 8'd1;
    i_dp_s1_rdy_1 = r1; i_dp_s1_tag_1 = t1; i_dp_s1_dat_1 = d1;
    i_dp_s2_rdy_1 = r2; i_dp_s2_tag_1 = t2; i_dp_s2_dat_1 = d2;
  endtask

  task automatic slot2(input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                       input logic r2, input logic [5:0] t2, input logic [31:0] d2);
    i_dp_vld_2 = 1'b1; i_dp_op_2 = uid; i_dp_dst_2 = uid[5:0]; uid = uid + 8'd1;
    i_dp_s1_rdy_2 = r1; i_dp_s1_tag_2 = t1; i_dp_s1_dat_2 = d1;
    i_dp_s2_rdy_2 = r2; i_dp_s2_tag_2 = t2; i_dp_s2_dat_2 = d2;
  endtask

  // Model: a bag of pending instructions; any ready one may issue, capacity is 2.
  task automatic cycle();
    int req, k;
    bit exp_alloc, exp_vld;
    ins_t n;
    @(negedge clk);
    req = int'(i_dp_vld_1) + int'(i_dp_vld_2);
    exp_alloc = (mq.size() + req) <= 2;
    chk("allocable", o_allocable, exp_alloc);
    exp_vld = 1'b0;
    foreach (mq[j]) if (mq[j].r1 && mq[j].r2) exp_vld = 1'b1;
    chk("iss_vld", o_iss_vld, exp_vld);
    k = -1;
    if (o_iss_vld && exp_vld) begin
      foreach (mq[j])
        if (mq[j].r1 && mq[j].r2 && mq[j].op == o_iss_op && mq[j].dst == o_iss_dst &&
            mq[j].d1 == o_iss_s1 && mq[j].d2 == o_iss_s2) k = j;
      chk("iss_payload", k >= 0, 1'b1);
    end
    if (i_flush) mq.delete();
    else begin
      if (k >= 0 && i_iss_rdy) mq.delete(k);
      if (exp_alloc && i_dp_vld_1) begin
        n = '{op: i_dp_op_1, dst: i_dp_dst_1, r1: i_dp_s1_rdy_1, t1: i_dp_s1_tag_1, d1: i_dp_s1_dat_1,
              r2: i_dp_s2_rdy_1, t2: i_dp_s2_tag_1, d2: i_dp_s2_dat_1};
        mq.push_back(n);
      end
      if (exp_alloc && i_dp_vld_2) begin
        n = '{op: i_dp_op_2, dst: i_dp_dst_2, r1: i_dp_s1_rdy_2, t1: i_dp_s1_tag_2, d1: i_dp_s1_dat_2,
              r2: i_dp_s2_rdy_2, t2: i_dp_s2_tag_2, d2: i_dp_s2_dat_2};
        mq.push_back(n);
      end
      foreach (mq[j]) begin
        if (!mq[j].r1 && i_cdb_vld_1 && i_cdb_tag_1 == mq[j].t1) begin mq[j].r1 = 1'b1; mq[j].d1 = i_cdb_dat_1; end
        else if (!mq[j].r1 && i_cdb_vld_2 && i_cdb_tag_2 == mq[j].t1) begin mq[j].r1 = 1'b1; mq[j].d1 = i_cdb_dat_2; end
        if (!mq[j].r2 && i_cdb_vld_1 && i_cdb_tag_1 == mq[j].t2) begin mq[j].r2 = 1'b1; mq[j].d2 = i_cdb_dat_1; end
        else if (!mq[j].r2 && i_cdb_vld_2 && i_cdb_tag_2 == mq[j].t2) begin mq[j].r2 = 1'b1; mq[j].d2 = i_cdb_dat_2; end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int free;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc", o_allocable, 1'b1);
    chk("rst_vld", o_iss_vld, 1'b0);
    chk("rst_op", o_iss_op, 8'h00);
    chk("rst_dst", o_iss_dst, 6'h00);
    chk("rst_s1", o_iss_s1, 32'h0);
    chk("rst_s2", o_iss_s2, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fill with two ready ops, drain both
    slot1(1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h12);
    slot2(1'b1, 6'd0, 32'h21, 1'b1, 6'd0, 32'h22);
    cycle();
    idle(); i_dp_vld_1 = 1'b1; #1;
    chk("t1_full", o_allocable, 1'b0);
    idle(); i_iss_rdy = 1'b1; #1;
    chk("t1_vld", o_iss_vld, 1'b1);
    cycle(); cycle();
    idle(); i_dp_vld_1 = 1'b1; i_dp_vld_2 = 1'b1; #1;
    chk("t1_empty_alloc", o_allocable, 1'b1);
    chk("t1_empty_vld", o_iss_vld, 1'b0);

    // 2: wakeup via CDB, visible one cycle later
    idle(); slot1(1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h77);
    cycle();
    idle(); i_cdb_vld_1 = 1'b1; i_cdb_tag_1 = 6'd5; i_cdb_dat_1 = 32'hDEAD; #1;
    chk("t2_no_bypass", o_iss_vld, 1'b0);
    cycle();
    idle(); #1;
    chk("t2_vld", o_iss_vld, 1'b1);
    chk("t2_s1", o_iss_s1, 32'hDEAD);
    i_iss_rdy = 1'b1; cycle();

    // 3: dispatch-time bypass on source 2 via CDB port 2
    idle(); slot1(1'b1, 6'd0, 32'h55, 1'b0, 6'd9, 32'h0);
    i_cdb_vld_2 = 1'b1; i_cdb_tag_2 = 6'd9; i_cdb_dat_2 = 32'h1234;
    cycle();
    idle(); #1;
    chk("t3_vld", o_iss_vld, 1'b1);
    chk("t3_s2", o_iss_s2, 32'h1234);
    i_iss_rdy = 1'b1; cycle();

    // 4: back-pressure holds payload
    idle(); slot1(1'b1, 6'd0, 32'hA1, 1'b1, 6'd0, 32'hA2);
    cycle();
    idle(); #1;
    sv_op = i_dp_op_1; sv_dst = o_iss_dst; sv_s1 = o_iss_s1; sv_s2 = o_iss_s2;
    sv_op = uid - 8'd1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_vld", o_iss_vld, 1'b1);
      chk("t4_op", o_iss_op, sv_op);
      chk("t4_s1", o_iss_s1, 32'hA1);
      cycle();
    end
    i_dp_vld_1 = 1'b1; i_dp_vld_2 = 1'b1; #1;
    chk("t4_busy", o_allocable, 1'b0);
    idle(); i_iss_rdy = 1'b1; cycle();

    // 5: flush a full station while dispatching
    idle();
    slot1(1'b1, 6'd0, 32'hB1, 1'b1, 6'd0, 32'hB2);
    slot2(1'b0, 6'd7, 32'h0, 1'b1, 6'd0, 32'hB4);
    cycle();
    idle(); i_flush = 1'b1; slot1(1'b1, 6'd0, 32'hC1, 1'b1, 6'd0, 32'hC2); #1;
    chk("t5_vld_in_flush", o_iss_vld, 1'b1);
    cycle();
    idle(); #1;
    chk("t5_vld_after", o_iss_vld, 1'b0);
    i_dp_vld_1 = 1'b1; i_dp_vld_2 = 1'b1; #1;
    chk("t5_empty", o_allocable, 1'b1);

    // 6: same tag on both CDB ports, port 1 wins
    idle(); slot1(1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 32'hD2);
    cycle();
    idle(); i_cdb_vld_1 = 1'b1; i_cdb_tag_1 = 6'd3; i_cdb_dat_1 = 32'h111;
    i_cdb_vld_2 = 1'b1; i_cdb_tag_2 = 6'd3; i_cdb_dat_2 = 32'h222;
    cycle();
    idle(); #1;
    chk("t6_s1", o_iss_s1, 32'h111);
    i_iss_rdy = 1'b1; cycle();

    // async reset mid-operation
    idle(); slot1(1'b1, 6'd0, 32'hE1, 1'b1, 6'd0, 32'hE2);
    cycle();
    idle(); #2; rst_n = 1'b0; #1;
    chk("arst_vld", o_iss_vld, 1'b0);
    chk("arst_op", o_iss_op, 8'h00);
    mq.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      i_flush = ($urandom_range(0, 39) == 0);
      i_iss_rdy = ($urandom_range(0, 3) != 0);
      i_cdb_vld_1 = 1'($urandom_range(0, 1)); i_cdb_tag_1 = 6'($urandom_range(0, 7)); i_cdb_dat_1 = $urandom;
      i_cdb_vld_2 = 1'($urandom_range(0, 1)); i_cdb_tag_2 = 6'($urandom_range(0, 7)); i_cdb_dat_2 = $urandom;
      free = 2 - mq.size();
      if (free >= 1 && $urandom_range(0, 1) == 1)
        slot1(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
      if (free >= 2 && i_dp_vld_1 && $urandom_range(0, 1) == 1)
        slot2(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
